score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Downstream consumer of the Tetris game-logic stage.
- Accepts piece-lock and line-clear events from game logic.
- Keeps a 6-digit packed-BCD running score and a best score, saturating at 999999.
- Drives the six board seven-segment displays, showing either the score or the best score.
- Adds one BCD digit per cycle and uses a valid/ready handshake, so game logic can stall on it.

Parameters:
- PTS_LOCK, 24'h000001: BCD points added for a piece lock with no lines cleared.
- PTS_L1, 24'h000100: BCD points for 1 line.
- PTS_L2, 24'h000300: BCD points for 2 lines.
- PTS_L3, 24'h000500: BCD points for 3 lines.
- PTS_L4, 24'h000800: BCD points for 4 lines.

Ports:
- CLOCK_50 in 1: system clock; all state on its rising edge.
- RESET_N in 1: asynchronous active-low reset.
- evt_valid in 1: scoring event present.
- evt_lines in 3: lines cleared; 0 means a plain lock; 1-4 are line clears; 5-7 are illegal.
- evt_ready out 1: the block can accept an event this cycle.
- score_clear in 1: new-game pulse; zeroes the score only.
- show_best in 1: 1 means the HEX outputs show the best score; 0 means they show the score.
- score_bcd out 24: current score, packed BCD, digit 0 in [3:0].
- best_bcd out 24: best score, packed BCD.
- busy out 1: an addition is in progress.
- new_best out 1: one-cycle pulse when the best score is raised.
- HEX0..HEX5 out 7 each: active-low segments, bit0=a to bit6=g; HEX0 is the least-significant digit.

Behaviour:
- Async reset:
  - score_bcd=0, best_bcd=0, state IDLE, new_best=0.
  - HEX0..HEX5=7'b1000000 (displays "0").
- evt_ready = (state==IDLE) && !score_clear. Combinational, no dependency on evt_valid.
- Event accept = evt_valid && evt_ready.
  - On accept, latch the addend selected by evt_lines.
  - evt_lines 5-7 latch addend 0 and still run the full sequence.
- States:
  - IDLE.
  - ADD: 6 cycles, digit index k=0..5.
  - UPDATE: 1 cycle.
- ADD, each cycle for digit k:
  - sum = score[k] + addend[k] + carry.
  - If sum > 9, write sum+6 (low nibble) and set carry=1; otherwise write sum and set carry=0.
  - Carry is cleared on accept.
  - Score digits are written in place as they are computed.
- UPDATE:
  - If the carry out of digit 5 is 1, set score_bcd=24'h999999.
  - Then, if the final score (after saturation) > best_bcd, copy it to best_bcd and pulse new_best.
  - The comparison is a 24-bit unsigned compare; this is valid for packed BCD.
  - Return to IDLE.
- Latency: accept at edge T; score final and best updated at edge T+7; evt_ready high again in cycle T+7.
- busy = (state != IDLE).
- score_clear has priority over everything except reset:
  - In any state it zeroes score_bcd and carry and forces IDLE on the next edge.
  - It aborts an in-flight add with no best update.
  - best_bcd is never cleared by score_clear.
- score_clear and evt_valid in the same cycle: the event is not accepted (evt_ready=0); the source must hold it.
- Display:
  - Each HEXn is registered, one cycle after the selected source changes.
  - The source is digit n of best_bcd if show_best, else of score_bcd.
  - Nibble values A-F (unreachable) display all-off 7'b1111111.
  - show_best may toggle at any time; it affects nothing except the displays.

Optional Feature:
- Macro: SCORE_LEADING_ZERO_BLANK_EN.
- Defined:
  - HEX5..HEX1 show 7'b1111111 while their digit and all more-significant digits are 0.
  - HEX0 always shows its digit.
  - Reset values: HEX5..HEX1 = 7'b1111111.
- Undefined: all six digits are always displayed, with leading zeros.

Decomposition:
- Package tetris_score_pkg:
  - State enum {IDLE, ADD, UPDATE}.
  - NUM_DIGITS=6.
  - SEG_BLANK=7'b1111111.
  - BCD_MAX=24'h999999.
- Sub-module seg7_decoder: 4-bit digit in, 7-bit active-low segments out; combinational, instantiated 6 times.
- All registers stay in score_keeper.

Test Plan:
1. Reset, then evt_lines=1 accepted -> evt_ready low for 7 cycles; score_bcd=24'h000100, best_bcd=24'h000100, new_best pulses once; HEX2=7'b1111001.
2. Score 24'h000950 + evt_lines=2 -> decimal carry ripples; score_bcd=24'h001250 exactly 7 cycles after accept.
3. Score 24'h999800 + evt_lines=4 -> saturates to 24'h999999; best_bcd=24'h999999.
4. best=24'h000800, score_clear, then evt_lines=1 -> score=24'h000100, best stays 24'h000800, new_best stays 0; show_best=1 gives HEX2=7'b0000000 (digit 8).
5. score_clear asserted during ADD cycle 3 -> score_bcd=0 next edge, IDLE, best unchanged; evt_valid held with score_clear -> not accepted until score_clear drops.
6. evt_lines=6 -> 7-cycle busy, score unchanged, no new_best. With SCORE_LEADING_ZERO_BLANK_EN and score=24'h000040: HEX0=7'b1000000, HEX1=7'b0011001, HEX2..HEX5=7'b1111111.

Source files
------------

// File: rtl/tetris_score_pkg.sv
// Shared types, constants and the single-digit BCD adder used by the Tetris score keeper.
package tetris_score_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    UPDATE = 2'd2
  } state_e;

  localparam int          NUM_DIGITS = 6;
  localparam logic [6:0]  SEG_BLANK  = 7'b1111111;
  localparam logic [6:0]  SEG_ZERO   = 7'b1000000;
  localparam logic [23:0] BCD_MAX    = 24'h999999;

  // Returns {carry_out, digit}; a raw sum above 9 is corrected by adding 6.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       cin);
    logic [4:0] sum;
    logic [4:0] res;
    sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (sum > 5'd9) begin
      res = {1'b1, sum[3:0] + 4'd6};
    end else begin
      res = {1'b0, sum[3:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/score_keeper_seg7_decoder.sv
// BCD digit to active-low seven-segment pattern (bit0=a .. bit6=g); non-decimal codes go dark.
module seg7_decoder
  import tetris_score_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Segment lookup.
  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_keeper.sv
// Tetris score/best-score keeper: digit-serial BCD adder with saturation and registered HEX drive.
// Optional SCORE_LEADING_ZERO_BLANK_EN blanks leading zeros on HEX5..HEX1.
module score_keeper
  import tetris_score_pkg::*;
#(
  parameter logic [23:0] PTS_LOCK = 24'h000001,
  parameter logic [23:0] PTS_L1   = 24'h000100,
  parameter logic [23:0] PTS_L2   = 24'h000300,
  parameter logic [23:0] PTS_L3   = 24'h000500,
  parameter logic [23:0] PTS_L4   = 24'h000800
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        evt_valid,
  input  logic [2:0]  evt_lines,
  output logic        evt_ready,
  input  logic        score_clear,
  input  logic        show_best,
  output logic [23:0] score_bcd,
  output logic [23:0] best_bcd,
  output logic        busy,
  output logic        new_best,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HEX_HI_RST = SEG_BLANK;
`else
  localparam logic [6:0] HEX_HI_RST = SEG_ZERO;
`endif

  state_e      state_q, state_d;
  logic [2:0]  digit_q, digit_d;
  logic        carry_q, carry_d;
  logic [23:0] addend_q, addend_d;
  logic [23:0] score_q, score_d;
  logic [23:0] best_q, best_d;
  logic        new_best_q, new_best_d;
  logic [6:0]  hex_q [NUM_DIGITS];
  logic [6:0]  hex_d [NUM_DIGITS];
  logic [6:0]  seg_s [NUM_DIGITS];

  logic        evt_ready_s;
  logic        accept_s;
  logic [4:0]  dig_lsb_s;
  logic [4:0]  dig_sum_s;
  logic [23:0] final_s;
  logic [23:0] src_s;

  function automatic logic [23:0] addend_for(input logic [2:0] lines);
    logic [23:0] pts;
    case (lines)
      3'd0:    pts = PTS_LOCK;
      3'd1:    pts = PTS_L1;
      3'd2:    pts = PTS_L2;
      3'd3:    pts = PTS_L3;
      3'd4:    pts = PTS_L4;
      default: pts = 24'h000000;
    endcase
    return pts;
  endfunction

  assign evt_ready_s = (state_q == IDLE) && !score_clear;
  assign accept_s    = evt_valid && evt_ready_s;
  assign dig_lsb_s   = {digit_q, 2'b00};
  assign dig_sum_s   = bcd_digit_add(score_q[dig_lsb_s +: 4], addend_q[dig_lsb_s +: 4], carry_q);
  assign final_s     = carry_q ? BCD_MAX : score_q;

  // Next-state logic for the add sequencer, score and best score.
  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    carry_d    = carry_q;
    addend_d   = addend_q;
    score_d    = score_q;
    best_d     = best_q;
    new_best_d = 1'b0;
    if (score_clear) begin
      score_d = 24'h000000;
      carry_d = 1'b0;
      digit_d = 3'd0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            addend_d = addend_for(evt_lines);
            carry_d  = 1'b0;
            digit_d  = 3'd0;
            state_d  = ADD;
          end else begin
            state_d = IDLE;
          end
        end
        ADD: begin
          score_d[dig_lsb_s +: 4] = dig_sum_s[3:0];
          carry_d                 = dig_sum_s[4];
          if (digit_q == 3'd5) begin
            state_d = UPDATE;
          end else begin
            digit_d = digit_q + 3'd1;
          end
        end
        UPDATE: begin
          // Packed BCD orders the same as plain binary, so a raw compare is enough.
          score_d = final_s;
          if (final_s > best_q) begin
            best_d     = final_s;
            new_best_d = 1'b1;
          end else begin
            new_best_d = 1'b0;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Core state registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      digit_q    <= 3'd0;
      carry_q    <= 1'b0;
      addend_q   <= 24'h000000;
      score_q    <= 24'h000000;
      best_q     <= 24'h000000;
      new_best_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      carry_q    <= carry_d;
      addend_q   <= addend_d;
      score_q    <= score_d;
      best_q     <= best_d;
      new_best_q <= new_best_d;
    end
  end

  assign src_s = show_best ? best_q : score_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decoder u_dec (
      .digit_i (src_s[g*4 +: 4]),
      .seg_o   (seg_s[g])
    );
  end

  // Display next-state, with optional leading-zero blanking above HEX0.
  always_comb begin
    for (int g = 0; g < NUM_DIGITS; g++) begin
      hex_d[g] = seg_s[g];
    end
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    for (int g = 1; g < NUM_DIGITS; g++) begin
      if ((src_s >> (4 * g)) == 24'h000000) begin
        hex_d[g] = SEG_BLANK;
      end else begin
        hex_d[g] = seg_s[g];
      end
    end
`endif
  end

  // Display registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hex_q[0] <= SEG_ZERO;
      for (int g = 1; g < NUM_DIGITS; g++) begin
        hex_q[g] <= HEX_HI_RST;
      end
    end else begin
      for (int g = 0; g < NUM_DIGITS; g++) begin
        hex_q[g] <= hex_d[g];
      end
    end
  end

  assign evt_ready = evt_ready_s;
  assign busy      = (state_q != IDLE);
  assign score_bcd = score_q;
  assign best_bcd  = best_q;
  assign new_best  = new_best_q;
  assign HEX0      = hex_q[0];
  assign HEX1      = hex_q[1];
  assign HEX2      = hex_q[2];
  assign HEX3      = hex_q[3];
  assign HEX4      = hex_q[4];
  assign HEX5      = hex_q[5];

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: vector table, directed corner sequences, random events vs decimal model.
module tb_score_keeper;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N = 1'b0;
  logic        evt_valid = 1'b0;
  logic [2:0]  evt_lines = 3'd0;
  logic        score_clear = 1'b0;
  logic        show_best = 1'b0;
  logic        evt_ready, busy, new_best;
  logic [23:0] score_bcd, best_bcd;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [6:0]  hex_w [6];

  int n_pass = 0;
  int n_checks = 0;
  int score_m = 0;
  int best_m = 0;

  score_keeper dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .evt_valid   (evt_valid),
    .evt_lines   (evt_lines),
    .evt_ready   (evt_ready),
    .score_clear (score_clear),
    .show_best   (show_best),
    .score_bcd   (score_bcd),
    .best_bcd    (best_bcd),
    .busy        (busy),
    .new_best    (new_best),
    .HEX0        (HEX0),
    .HEX1        (HEX1),
    .HEX2        (HEX2),
    .HEX3        (HEX3),
    .HEX4        (HEX4),
    .HEX5        (HEX5)
  );

  assign hex_w[0] = HEX0;
  assign hex_w[1] = HEX1;
  assign hex_w[2] = HEX2;
  assign hex_w[3] = HEX3;
  assign hex_w[4] = HEX4;
  assign hex_w[5] = HEX5;

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int          lines;
    logic [23:0] exp_score;
    logic [23:0] exp_best;
    logic        exp_nb;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic int pts_for(input int lines);
    case (lines)
      0:       return 1;
      1:       return 100;
      2:       return 300;
      3:       return 500;
      4:       return 800;
      default: return 0;
    endcase
  endfunction

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r = 24'h000000;
    for (int i = 0; i < 6; i++) r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [6:0] seg_for(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_hex(input int n);
    int v = show_best ? best_m : score_m;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    if (n > 0 && v < pow10(n)) return 7'b1111111;
`endif
    return seg_for((v / pow10(n)) % 10);
  endfunction

  task automatic check_hex();
    for (int n = 0; n < 6; n++)
      check($sformatf("HEX%0d", n), 32'(hex_w[n]), 32'(exp_hex(n)));
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    RESET_N = 1'b0; evt_valid = 1'b0; score_clear = 1'b0; show_best = 1'b0;
    score_m = 0; best_m = 0;
    #3;
    check("rst_score", 32'(score_bcd), 32'd0);
    check("rst_best", 32'(best_bcd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_new_best", 32'(new_best), 32'd0);
    check("rst_ready", 32'(evt_ready), 32'd1);
    check_hex();
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
  endtask

  // One event end to end: 7 busy cycles, then final score/best and one-cycle new_best.
  task automatic send_event(input int lines, output logic nb_seen);
    int  n = 0;
    bit  win_ok = 1'b1;
    int  s;
    int  exp_nb;
    @(negedge CLOCK_50);
    while (evt_ready !== 1'b1 && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("ready_wait", 32'(evt_ready), 32'd1);
    evt_valid = 1'b1;
    evt_lines = 3'(lines);
    @(posedge CLOCK_50);
    #1 evt_valid = 1'b0;
    s = score_m + pts_for(lines);
    if (s > 999999) s = 999999;
    score_m = s;
    exp_nb = (s > best_m) ? 1 : 0;
    if (exp_nb == 1) best_m = s;
    repeat (7) begin
      @(negedge CLOCK_50);
      if (busy !== 1'b1 || evt_ready !== 1'b0 || new_best !== 1'b0) win_ok = 1'b0;
    end
    check("busy_window", 32'(win_ok), 32'd1);
    @(negedge CLOCK_50);
    check("busy_done", 32'(busy), 32'd0);
    check("ready_done", 32'(evt_ready), 32'd1);
    check("score", 32'(score_bcd), 32'(to_bcd(score_m)));
    check("best", 32'(best_bcd), 32'(to_bcd(best_m)));
    check("new_best", 32'(new_best), 32'(exp_nb));
    nb_seen = new_best;
    @(negedge CLOCK_50);
    check("new_best_end", 32'(new_best), 32'd0);
    check_hex();
  endtask

  task automatic pulse_clear();
    @(negedge CLOCK_50);
    score_clear = 1'b1;
    #1 check("ready_in_clear", 32'(evt_ready), 32'd0);
    @(posedge CLOCK_50);
    #1 score_clear = 1'b0;
    score_m = 0;
    @(negedge CLOCK_50);
    check("score_after_clear", 32'(score_bcd), 32'd0);
    check("best_after_clear", 32'(best_bcd), 32'(to_bcd(best_m)));
  endtask

  initial begin
    vec_t tbl[8];
    logic nb;
    bit   win_ok;

    tbl[0] = '{1, 24'h000100, 24'h000100, 1'b1};
    tbl[1] = '{0, 24'h000101, 24'h000101, 1'b1};
    tbl[2] = '{6, 24'h000101, 24'h000101, 1'b0};
    tbl[3] = '{2, 24'h000401, 24'h000401, 1'b1};
    tbl[4] = '{3, 24'h000901, 24'h000901, 1'b1};
    tbl[5] = '{4, 24'h001701, 24'h001701, 1'b1};
    tbl[6] = '{7, 24'h001701, 24'h001701, 1'b0};
    tbl[7] = '{5, 24'h001701, 24'h001701, 1'b0};

    do_reset();

    for (int i = 0; i < 8; i++) begin
      send_event(tbl[i].lines, nb);
      check($sformatf("tbl%0d_score", i), 32'(score_bcd), 32'(tbl[i].exp_score));
      check($sformatf("tbl%0d_best", i), 32'(best_bcd), 32'(tbl[i].exp_best));
      check($sformatf("tbl%0d_nb", i), 32'(nb), 32'(tbl[i].exp_nb));
      if (i == 0) check("tbl0_HEX2", 32'(HEX2), 32'(7'b1111001));
    end

    // Decimal carry ripple: 950 + 300.
    pulse_clear();
    for (int i = 0; i < 9; i++) send_event(1, nb);
    for (int i = 0; i < 50; i++) send_event(0, nb);
    check("ripple_pre", 32'(score_bcd), 32'(24'h000950));
    send_event(2, nb);
    check("ripple_post", 32'(score_bcd), 32'(24'h001250));

    // Best survives a new game; best shown on HEX.
    do_reset();
    send_event(4, nb);
    pulse_clear();
    send_event(1, nb);
    check("ng_score", 32'(score_bcd), 32'(24'h000100));
    check("ng_best", 32'(best_bcd), 32'(24'h000800));
    check("ng_nb", 32'(nb), 32'd0);
    show_best = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    check("show_best_HEX2", 32'(HEX2), 32'(7'b0000000));
    check_hex();
    show_best = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    check("show_score_HEX2", 32'(HEX2), 32'(7'b1111001));

    // Abort mid-add, then an event held against score_clear.
    do_reset();
    send_event(4, nb);
    @(negedge CLOCK_50);
    evt_valid = 1'b1; evt_lines = 3'd1;
    @(posedge CLOCK_50);
    #1 evt_valid = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    check("abort_busy_mid", 32'(busy), 32'd1);
    score_clear = 1'b1;
    @(negedge CLOCK_50);
    check("abort_score", 32'(score_bcd), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_best", 32'(best_bcd), 32'(24'h000800));
    evt_valid = 1'b1; evt_lines = 3'd1;
    #1 check("held_ready_low", 32'(evt_ready), 32'd0);
    @(negedge CLOCK_50);
    check("held_not_accepted", 32'(busy), 32'd0);
    score_clear = 1'b0;
    #1 check("held_ready_high", 32'(evt_ready), 32'd1);
    @(posedge CLOCK_50);
    #1 evt_valid = 1'b0;
    score_m = 100; best_m = 800;
    win_ok = 1'b1;
    repeat (7) begin
      @(negedge CLOCK_50);
      if (busy !== 1'b1 || new_best !== 1'b0) win_ok = 1'b0;
    end
    check("held_window", 32'(win_ok), 32'd1);
    @(negedge CLOCK_50);
    check("held_score", 32'(score_bcd), 32'(24'h000100));
    check("held_best", 32'(best_bcd), 32'(24'h000800));
    check("held_nb", 32'(new_best), 32'd0);

    // Display of 40, with or without blanking.
    do_reset();
    for (int i = 0; i < 40; i++) send_event(0, nb);
    check("d40_HEX0", 32'(HEX0), 32'(7'b1000000));
    check("d40_HEX1", 32'(HEX1), 32'(7'b0011001));
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    check("d40_HEX2", 32'(HEX2), 32'(7'b1111111));
    check("d40_HEX5", 32'(HEX5), 32'(7'b1111111));
`else
    check("d40_HEX2", 32'(HEX2), 32'(7'b1000000));
    check("d40_HEX5", 32'(HEX5), 32'(7'b1000000));
`endif

    // Random events, clears and display selection against the model.
    for (int i = 0; i < 150; i++) begin
      show_best = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) pulse_clear();
      else send_event(int'($urandom_range(0, 7)), nb);
    end
    show_best = 1'b0;

    // Saturation at 999999.
    do_reset();
    for (int i = 0; i < 1249; i++) send_event(4, nb);
    send_event(3, nb);
    send_event(1, nb);
    check("sat_pre", 32'(score_bcd), 32'(24'h999800));
    send_event(4, nb);
    check("sat_score", 32'(score_bcd), 32'(24'h999999));
    check("sat_best", 32'(best_bcd), 32'(24'h999999));
    check("sat_nb", 32'(nb), 32'd1);
    send_event(1, nb);
    check("sat_hold", 32'(score_bcd), 32'(24'h999999));
    check("sat_hold_nb", 32'(nb), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
